cpu_hazard_unit: RTL and testbench

- Parametrised scoreboard, forwarding and stall unit for the RV32 pipeline, sized for deeper pipelines.
- Tracks up to STAGES in-flight results after execute issue.
- Every cycle it selects forwarded operand data for the execute operands (rs1/rs2) and for the register-indirect jump operand.
- Raises exe/jump stalls when a load result is not yet available; supports a configurable load latency and flush depth.

---
 rtl/cpu_hazard_if.sv | 39 +++
 rtl/cpu_hazard_unit.sv | 89 ++++++++
 tb/tb_cpu_hazard_unit.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_hazard_if.sv
// Issue, operand, jump and stall signals between the pipeline and the hazard unit.
interface cpu_hazard_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 3,
  parameter int unsigned CNT_W  = 16
);
  logic                     issue_valid;
  logic [4:0]               issue_rd;
  logic                     issue_wr_en;
  logic                     issue_is_load;
  logic [1:0]               issue_rs_en;
  logic [4:0]               issue_rs1;
  logic [4:0]               issue_rs2;
  logic [XLEN-1:0]          rf_data1;
  logic [XLEN-1:0]          rf_data2;
  logic                     jmp_reg_en;
  logic [4:0]               jmp_rs;
  logic [XLEN-1:0]          rf_jmp;
  logic [STAGES*XLEN-1:0]   stage_data;
  logic                     flush;
  logic [XLEN-1:0]          fwd_data1;
  logic [XLEN-1:0]          fwd_data2;
  logic [XLEN-1:0]          jmp_data;
  logic                     stall_exe;
  logic                     stall_jmp;
  logic [CNT_W-1:0]         stall_cnt;

  modport master (
    output issue_valid, issue_rd, issue_wr_en, issue_is_load, issue_rs_en, issue_rs1, issue_rs2,
    output rf_data1, rf_data2, jmp_reg_en, jmp_rs, rf_jmp, stage_data, flush,
    input  fwd_data1, fwd_data2, jmp_data, stall_exe, stall_jmp, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_rd, issue_wr_en, issue_is_load, issue_rs_en, issue_rs1, issue_rs2,
    input  rf_data1, rf_data2, jmp_reg_en, jmp_rs, rf_jmp, stage_data, flush,
    output fwd_data1, fwd_data2, jmp_data, stall_exe, stall_jmp, stall_cnt
  );
endinterface

// File: rtl/cpu_hazard_unit.sv
// Scoreboard of in-flight results: operand forwarding, load-use and jump-base stalls.
module cpu_hazard_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned STAGES      = 3,
  parameter int unsigned LOAD_LAT    = 2,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned CNT_W       = 16
) (
  input logic         clk,
  input logic         rst_n,
  cpu_hazard_if.slave bus
);
  // Index 0 holds entry 1 (issued one cycle ago).
  logic [STAGES-1:0]      valid_q, valid_d;
  logic [STAGES-1:0]      wr_en_q, wr_en_d;
  logic [STAGES-1:0]      load_q, load_d;
  logic [STAGES-1:0][4:0] rd_q, rd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Lookups: 0 = rs1, 1 = rs2, 2 = jump base.
  logic [2:0][4:0]   req;
  logic [2:0]        hit;
  logic [2:0]        early;
  logic [XLEN-1:0]   data [3];
  logic              haz1, haz2, issue_hit;

  always_comb begin
    req = {bus.jmp_rs, bus.issue_rs2, bus.issue_rs1};
    for (int unsigned i = 0; i < 3; i++) begin
      hit[i]   = 1'b0;
      early[i] = 1'b0;
      data[i]  = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (!hit[i] && valid_q[k] && wr_en_q[k] && rd_q[k] == req[i] && req[i] != 5'd0) begin
          hit[i]   = 1'b1;
          early[i] = load_q[k] && (k + 1 < LOAD_LAT);
          data[i]  = bus.stage_data[k*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    haz1      = bus.issue_rs_en[1] & hit[0] & early[0];
    haz2      = bus.issue_rs_en[0] & hit[1] & early[1];
    issue_hit = bus.issue_valid & bus.issue_wr_en & (bus.issue_rd == bus.jmp_rs);

    bus.fwd_data1 = (bus.issue_rs_en[1] & hit[0]) ? data[0] : bus.rf_data1;
    bus.fwd_data2 = (bus.issue_rs_en[0] & hit[1]) ? data[1] : bus.rf_data2;
    bus.jmp_data  = hit[2] ? data[2] : bus.rf_jmp;
    // Stalls are forced low while reset is held, even with hazardous issue inputs.
    bus.stall_exe = rst_n & bus.issue_valid & (haz1 | haz2);
    bus.stall_jmp = rst_n & bus.jmp_reg_en & (bus.jmp_rs != 5'd0) &
                    (issue_hit | (hit[2] & early[2]));
    bus.stall_cnt = cnt_q;
  end

  always_comb begin
    valid_d[0] = bus.issue_valid & ~bus.stall_exe & ~bus.flush;
    wr_en_d[0] = bus.issue_wr_en;
    load_d[0]  = bus.issue_is_load;
    rd_d[0]    = bus.issue_rd;
    // Entry k-1 moves to slot k; it dies on flush if it was among the youngest FLUSH_DEPTH.
    for (int unsigned k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1] & ~(bus.flush & (k <= FLUSH_DEPTH));
      wr_en_d[k] = wr_en_q[k-1];
      load_d[k]  = load_q[k-1];
      rd_d[k]    = rd_q[k-1];
    end
    cnt_d = cnt_q;
    if ((bus.stall_exe | bus.stall_jmp) && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      wr_en_q <= '0;
      load_q  <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wr_en_q <= wr_en_d;
      load_q  <= load_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_cpu_hazard_unit.sv
// Self-checking bench for cpu_hazard_unit: directed scenarios plus random traffic vs a model.
module tb_cpu_hazard_unit;
  localparam int XLEN        = 32;
  localparam int STAGES      = 3;
  localparam int LOAD_LAT    = 2;
  localparam int FLUSH_DEPTH = 1;
  localparam int CNT_W       = 16;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  cpu_hazard_if #(.XLEN(XLEN), .STAGES(STAGES), .CNT_W(CNT_W)) bus ();

  cpu_hazard_unit #(
    .XLEN(XLEN), .STAGES(STAGES), .LOAD_LAT(LOAD_LAT), .FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of in-flight instructions, index 1 = issued one cycle ago.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
  } ent_t;
  ent_t            ent [1:STAGES];
  int              m_cnt;
  logic [XLEN-1:0] exp_f1, exp_f2, exp_j;
  logic            exp_se, exp_sj;

  function automatic logic [XLEN-1:0] slice(input int k);
    return bus.stage_data[(k-1)*XLEN +: XLEN];
  endfunction

  task automatic resolve(input logic [4:0] r, input logic [XLEN-1:0] rf,
                         output logic [XLEN-1:0] d, output bit not_ready);
    d = rf;
    not_ready = 0;
    if (r != 5'd0) begin
      for (int k = 1; k <= STAGES; k++) begin
        if (ent[k].v && ent[k].wr && ent[k].rd == r) begin
          d = slice(k);
          not_ready = ent[k].ld && (k < LOAD_LAT);
          break;
        end
      end
    end
  endtask

  task automatic model_eval();
    bit h1, h2, hj;
    resolve(bus.issue_rs1, bus.rf_data1, exp_f1, h1);
    resolve(bus.issue_rs2, bus.rf_data2, exp_f2, h2);
    if (!bus.issue_rs_en[1]) begin exp_f1 = bus.rf_data1; h1 = 0; end
    if (!bus.issue_rs_en[0]) begin exp_f2 = bus.rf_data2; h2 = 0; end
    resolve(bus.jmp_rs, bus.rf_jmp, exp_j, hj);
    exp_se = bus.issue_valid && (h1 || h2);
    exp_sj = bus.jmp_reg_en && bus.jmp_rs != 5'd0 &&
             ((bus.issue_valid && bus.issue_wr_en && bus.issue_rd == bus.jmp_rs) || hj);
  endtask

  task automatic model_reset();
    for (int k = 1; k <= STAGES; k++) ent[k] = '{v: 0, rd: 0, wr: 0, ld: 0};
    m_cnt = 0;
  endtask

  task automatic model_step();
    if ((exp_se || exp_sj) && m_cnt < CNT_MAX) m_cnt++;
    if (bus.flush) for (int k = 1; k <= FLUSH_DEPTH; k++) ent[k].v = 0;
    for (int k = STAGES; k >= 2; k--) ent[k] = ent[k-1];
    ent[1].v  = bus.issue_valid && !exp_se && !bus.flush;
    ent[1].rd = bus.issue_rd;
    ent[1].wr = bus.issue_wr_en;
    ent[1].ld = bus.issue_is_load;
  endtask

  // Advance one clock; returns 1 time unit after the rising edge.
  task automatic tick();
    model_eval();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    bus.issue_valid   = 1'b0;
    bus.issue_rd      = 5'd0;
    bus.issue_wr_en   = 1'b0;
    bus.issue_is_load = 1'b0;
    bus.issue_rs_en   = 2'b00;
    bus.issue_rs1     = 5'd0;
    bus.issue_rs2     = 5'd0;
    bus.rf_data1      = 32'h1111_0001;
    bus.rf_data2      = 32'h2222_0002;
    bus.jmp_reg_en    = 1'b0;
    bus.jmp_rs        = 5'd0;
    bus.rf_jmp        = 32'h3333_0003;
    bus.stage_data    = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    bus.flush         = 1'b0;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    #2;
    n_checks++; if (bus.stall_cnt !== '0)
      begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", bus.stall_cnt); end
    n_checks++; if (bus.stall_exe !== 1'b0 || bus.stall_jmp !== 1'b0)
      begin n_errors++; $display("FAIL reset_stall: got %b%b want 00", bus.stall_exe, bus.stall_jmp); end
    bus.issue_rs_en = 2'b11; bus.issue_rs1 = 5'd4; bus.issue_rs2 = 5'd9;
    bus.jmp_reg_en = 1'b1; bus.jmp_rs = 5'd4;
    #1;
    n_checks++; if (bus.fwd_data1 !== bus.rf_data1 || bus.fwd_data2 !== bus.rf_data2 ||
                    bus.jmp_data !== bus.rf_jmp)
      begin n_errors++; $display("FAIL reset_passthru: got %h %h %h want %h %h %h", bus.fwd_data1,
            bus.fwd_data2, bus.jmp_data, bus.rf_data1, bus.rf_data2, bus.rf_jmp); end
    @(posedge clk); #1;
    apply_reset();
  endtask

  task automatic test_forward();
    apply_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.issue_wr_en = 1'b1;
    tick();
    bus.issue_rd = 5'd9; bus.issue_rs1 = 5'd5; bus.issue_rs_en = 2'b10;
    bus.stage_data[0 +: XLEN] = 32'h0000_1234;
    #1;
    n_checks++; if (bus.fwd_data1 !== 32'h0000_1234)
      begin n_errors++; $display("FAIL fwd_alu: got %h want 00001234", bus.fwd_data1); end
    n_checks++; if (bus.stall_exe !== 1'b0)
      begin n_errors++; $display("FAIL fwd_alu_stall: got %b want 0", bus.stall_exe); end
    tick();
  endtask

  task automatic test_load_use();
    apply_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd6; bus.issue_wr_en = 1'b1; bus.issue_is_load = 1'b1;
    tick();
    bus.issue_rd = 5'd7; bus.issue_is_load = 1'b0;
    bus.issue_rs1 = 5'd6; bus.issue_rs2 = 5'd6; bus.issue_rs_en = 2'b11;
    #1;
    n_checks++; if (bus.stall_exe !== 1'b1)
      begin n_errors++; $display("FAIL load_use_stall: got %b want 1", bus.stall_exe); end
    tick();
    n_checks++; if (bus.stall_exe !== 1'b0)
      begin n_errors++; $display("FAIL load_use_release: got %b want 0", bus.stall_exe); end
    n_checks++; if (bus.stall_cnt !== 16'd1)
      begin n_errors++; $display("FAIL load_use_cnt: got %0d want 1", bus.stall_cnt); end
    n_checks++; if (bus.fwd_data1 !== 32'hBBBB_0002 || bus.fwd_data2 !== 32'hBBBB_0002)
      begin n_errors++; $display("FAIL load_use_fwd: got %h %h want bbbb0002", bus.fwd_data1,
            bus.fwd_data2); end
    tick();
  endtask

  task automatic test_youngest_and_x0();
    apply_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3; bus.issue_wr_en = 1'b1;
    tick();
    tick();
    bus.issue_rd = 5'd12; bus.issue_rs1 = 5'd3; bus.issue_rs_en = 2'b10;
    bus.stage_data[0 +: XLEN] = 32'hA; bus.stage_data[XLEN +: XLEN] = 32'hB;
    #1;
    n_checks++; if (bus.fwd_data1 !== 32'hA)
      begin n_errors++; $display("FAIL youngest_wins: got %h want a", bus.fwd_data1); end
    apply_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.issue_wr_en = 1'b1; bus.issue_is_load = 1'b1;
    tick();
    bus.issue_is_load = 1'b0; bus.issue_rs1 = 5'd0; bus.issue_rs2 = 5'd0; bus.issue_rs_en = 2'b11;
    #1;
    n_checks++; if (bus.fwd_data1 !== bus.rf_data1 || bus.stall_exe !== 1'b0)
      begin n_errors++; $display("FAIL x0_passthru: got %h stall %b want %h stall 0",
            bus.fwd_data1, bus.stall_exe, bus.rf_data1); end
    tick();
  endtask

  task automatic test_jump();
    apply_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd1; bus.issue_wr_en = 1'b1;
    bus.jmp_reg_en = 1'b1; bus.jmp_rs = 5'd1;
    #1;
    n_checks++; if (bus.stall_jmp !== 1'b1)
      begin n_errors++; $display("FAIL jmp_issue_stall: got %b want 1", bus.stall_jmp); end
    tick();
    bus.issue_valid = 1'b0; bus.stage_data[0 +: XLEN] = 32'h80;
    #1;
    n_checks++; if (bus.jmp_data !== 32'h80 || bus.stall_jmp !== 1'b0)
      begin n_errors++; $display("FAIL jmp_fwd: got %h stall %b want 80 stall 0", bus.jmp_data,
            bus.stall_jmp); end
    tick();
  endtask

  task automatic test_flush();
    apply_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd8; bus.issue_wr_en = 1'b1; bus.issue_is_load = 1'b1;
    tick();
    bus.issue_valid = 1'b0; bus.issue_is_load = 1'b0; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.issue_valid = 1'b1; bus.issue_rd = 5'd10;
    bus.issue_rs1 = 5'd8; bus.issue_rs2 = 5'd8; bus.issue_rs_en = 2'b11;
    #1;
    n_checks++; if (bus.stall_exe !== 1'b0)
      begin n_errors++; $display("FAIL flush_stall: got %b want 0", bus.stall_exe); end
    n_checks++; if (bus.fwd_data1 !== bus.rf_data1 || bus.fwd_data2 !== bus.rf_data2)
      begin n_errors++; $display("FAIL flush_passthru: got %h %h want %h %h", bus.fwd_data1,
            bus.fwd_data2, bus.rf_data1, bus.rf_data2); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd1; bus.issue_wr_en = 1'b1;
    bus.jmp_reg_en = 1'b1; bus.jmp_rs = 5'd1;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (bus.stall_cnt !== 16'd5)
      begin n_errors++; $display("FAIL stall_cnt_5: got %0d want 5", bus.stall_cnt); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.stall_exe !== 1'b0 || bus.stall_jmp !== 1'b0 || bus.stall_cnt !== '0)
      begin n_errors++; $display("FAIL async_reset: got exe %b jmp %b cnt %0d want 0 0 0",
            bus.stall_exe, bus.stall_jmp, bus.stall_cnt); end
    rst_n = 1'b1;
    model_reset();
    bus.issue_valid = 1'b0; bus.jmp_reg_en = 1'b0;
    bus.issue_rs1 = 5'd1; bus.issue_rs_en = 2'b10;
    #1;
    n_checks++; if (bus.fwd_data1 !== bus.rf_data1)
      begin n_errors++; $display("FAIL reset_empty: got %h want %h", bus.fwd_data1,
            bus.rf_data1); end
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      bus.issue_valid   = ($urandom_range(0, 3) != 0);
      bus.issue_rd      = 5'($urandom_range(0, 7));
      bus.issue_wr_en   = ($urandom_range(0, 4) != 0);
      bus.issue_is_load = ($urandom_range(0, 2) == 0);
      bus.issue_rs_en   = 2'($urandom_range(0, 3));
      bus.issue_rs1     = 5'($urandom_range(0, 7));
      bus.issue_rs2     = 5'($urandom_range(0, 7));
      bus.rf_data1      = $urandom();
      bus.rf_data2      = $urandom();
      bus.jmp_reg_en    = ($urandom_range(0, 2) == 0);
      bus.jmp_rs        = 5'($urandom_range(0, 7));
      bus.rf_jmp        = $urandom();
      for (int k = 0; k < STAGES; k++) bus.stage_data[k*XLEN +: XLEN] = $urandom();
      bus.flush         = ($urandom_range(0, 9) == 0);
      #1;
      model_eval();
      n_checks++; if (bus.fwd_data1 !== exp_f1)
        begin n_errors++; $display("FAIL rnd_fwd1 @%0d: got %h want %h", i, bus.fwd_data1, exp_f1); end
      n_checks++; if (bus.fwd_data2 !== exp_f2)
        begin n_errors++; $display("FAIL rnd_fwd2 @%0d: got %h want %h", i, bus.fwd_data2, exp_f2); end
      n_checks++; if (bus.jmp_data !== exp_j)
        begin n_errors++; $display("FAIL rnd_jmp @%0d: got %h want %h", i, bus.jmp_data, exp_j); end
      n_checks++; if (bus.stall_exe !== exp_se)
        begin n_errors++; $display("FAIL rnd_stall_exe @%0d: got %b want %b", i, bus.stall_exe, exp_se); end
      n_checks++; if (bus.stall_jmp !== exp_sj)
        begin n_errors++; $display("FAIL rnd_stall_jmp @%0d: got %b want %b", i, bus.stall_jmp, exp_sj); end
      n_checks++; if (32'(bus.stall_cnt) !== m_cnt)
        begin n_errors++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", i, bus.stall_cnt, m_cnt); end
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    test_reset();
    test_forward();
    test_load_use();
    test_youngest_and_x0();
    test_jump();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
